uart_rx: RTL and testbench

Serial receiver that sits directly downstream of `uart_tx` and consumes its `tx_line`. It recovers frames of one start bit (0), `DATABITS` data bits LSB first, one even-parity bit and one stop bit (1) using a 16x oversampling tick. It presents each received byte as a one-cycle `rx_valid` pulse with parity and framing status.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for uart_tx / uart_rx.
//   - rx_state_t     : receiver FSM state encoding
//   - *_DEF          : default frame width and oversample ratio
//   - start/stop bit : line levels used by both ends of the link
package uart_pkg;

  localparam int UART_DATABITS_DEF   = 8;
  localparam int UART_OVERSAMPLE_DEF = 16;

  // Line levels for the framing bits; idle is the same level as stop.
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for a single asynchronous bit.
// Ports: clk, reset (sync, active-high), d (async input), q (synchronized).
// Latency: 2 clk cycles. RESET_VAL sets both flops on reset so an idle
// line level can be presented from the first cycle after reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (start, DATABITS LSB first,
// optional even parity, stop). Emits a one-cycle rx_valid per frame.
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   os_tick        : oversample enable, OVERSAMPLE pulses per bit period
//   rx_line        : asynchronous serial input, idles high
//   rx_data        : last received word (held until the next rx_valid)
//   rx_valid       : one-cycle frame-complete pulse
//   parity_err     : received parity bit != ^rx_data (qualified by rx_valid)
//   frame_err      : stop bit sampled low (qualified by rx_valid)
//   rx_busy        : high whenever the FSM is not idle
// Build option: define UART_RX_PARITY_EN to receive a parity bit between
// the data and stop bits; otherwise the frame has no parity and
// parity_err is constant 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATABITS   = UART_DATABITS_DEF,
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                os_tick,
  input  logic                rx_line,
  output logic [DATABITS-1:0] rx_data,
  output logic                rx_valid,
  output logic                parity_err,
  output logic                frame_err,
  output logic                rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);

  // Terminal counts: the start bit is sampled half a bit period after the
  // falling edge, every later bit one full period after the previous one.
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATABITS - 1);

  localparam logic [2:0] S_IDLE   = 3'(RX_IDLE);
  localparam logic [2:0] S_START  = 3'(RX_START);
  localparam logic [2:0] S_DATA   = 3'(RX_DATA);
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'(RX_PARITY);
`endif
  localparam logic [2:0] S_STOP   = 3'(RX_STOP);
  localparam logic [2:0] S_BREAK  = 3'(RX_BREAK);

  logic                rx_s;
  logic [2:0]          state;
  logic [TW-1:0]       tick_cnt;
  logic [3:0]          bit_cnt;
  logic [DATABITS-1:0] shift;
  logic                half_pt;
  logic                full_pt;
`ifdef UART_RX_PARITY_EN
  logic                par_s;
`endif

  // Idle-high reset value keeps the FSM from seeing a false start bit
  // while the synchronizer fills after reset.
  uart_sync2 #(
    .RESET_VAL (UART_STOP_BIT)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_line),
    .q     (rx_s)
  );

  assign half_pt = os_tick && (tick_cnt == HALF_LAST);
  assign full_pt = os_tick && (tick_cnt == FULL_LAST);
  assign rx_busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_s      <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;

      case (state)
        // Edge detection does not wait for a tick, so a start bit that
        // follows the stop bit directly is caught on the next cycle.
        S_IDLE: begin
          if (rx_s == UART_START_BIT) begin
            tick_cnt <= '0;
            state    <= S_START;
          end
        end

        S_START: begin
          if (half_pt) begin
            tick_cnt <= '0;
            if (rx_s != UART_START_BIT) begin
              // Line back high at mid-bit: treat the low as a glitch.
              state <= S_IDLE;
            end else begin
              bit_cnt <= '0;
              state   <= S_DATA;
            end
          end else if (os_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (full_pt) begin
            tick_cnt <= '0;
            // Bits arrive LSB first: insert at the MSB and shift right so
            // that after DATABITS samples the first bit sits at bit 0.
            shift <= (shift >> 1) | (DATABITS'(rx_s) << (DATABITS - 1));
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (os_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (full_pt) begin
            tick_cnt <= '0;
            par_s    <= rx_s;
            state    <= S_STOP;
          end else if (os_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
`endif

        // Frames are delivered even when malformed; status flags let the
        // consumer decide what to drop.
        S_STOP: begin
          if (full_pt) begin
            tick_cnt   <= '0;
            rx_data    <= shift;
            frame_err  <= (rx_s != UART_STOP_BIT);
`ifdef UART_RX_PARITY_EN
            parity_err <= par_s ^ (^shift);
`endif
            rx_valid   <= 1'b1;
            state      <= (rx_s == UART_STOP_BIT) ? S_IDLE : S_BREAK;
          end else if (os_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        // Line held low past the stop bit: wait for it to release before
        // hunting for the next start edge.
        S_BREAK: begin
          if (rx_s == UART_STOP_BIT) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames driven onto rx_line; each
// delivered frame is checked against an expected-frame queue built from the
// bits actually sent.
module tb_uart_rx;

  localparam int DB = 8;
  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int NBITS = 2 + DB + PAR_EN;

  logic          clk = 1'b0;
  logic          reset;
  logic          os_tick;
  logic          rx_line;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          parity_err;
  logic          frame_err;
  logic          rx_busy;

  int checks   = 0;
  int failures = 0;
  int tdiv     = 4;
  int ph       = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int n_sent   = 0;
  int t_prev   = 0;
  int t_last   = 0;
  logic prev_valid = 1'b0;

  // Expected frames: {parity_err, frame_err, data}
  logic [DB+1:0] exp_q[$];
  logic [DB+1:0] mon_e;

  uart_rx #(
    .DATABITS   (DB),
    .OVERSAMPLE (OS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .os_tick    (os_tick),
    .rx_line    (rx_line),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Oversample tick: one pulse every tdiv clocks (tdiv = 1 holds it high).
  initial begin
    os_tick = 1'b0;
    forever begin
      @(negedge clk);
      os_tick = (ph == 0);
      ph = (ph + 1 >= tdiv) ? 0 : ph + 1;
    end
  end

  // Output monitor: every rx_valid must match the oldest expected frame.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      t_prev = t_last;
      t_last = cyc;
      checks++;
      assert (prev_valid === 1'b0) else begin
        failures++;
        $error("FAIL valid_width obs=%0d exp=%0d", prev_valid, 0);
      end
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_valid obs=%0h exp=none", rx_data);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        assert (rx_data === mon_e[DB-1:0]) else begin
          failures++;
          $error("FAIL rx_data obs=%0h exp=%0h", rx_data, mon_e[DB-1:0]);
        end
        checks++;
        assert (frame_err === mon_e[DB]) else begin
          failures++;
          $error("FAIL frame_err obs=%0d exp=%0d (data %0h)", frame_err, mon_e[DB], mon_e[DB-1:0]);
        end
        checks++;
        assert (parity_err === mon_e[DB+1]) else begin
          failures++;
          $error("FAIL parity_err obs=%0d exp=%0d (data %0h)", parity_err, mon_e[DB+1], mon_e[DB-1:0]);
        end
      end
    end
    prev_valid = rx_valid;
  end

  initial begin
    #900000;
    $display("FAIL watchdog obs=timeout exp=finish checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    repeat (OS * tdiv) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx_line = 1'b1;
    repeat (OS * tdiv * n) @(negedge clk);
  endtask

  // Queue what the receiver must report for these exact line bits, then
  // put the frame on the wire.
  task automatic send_frame(input logic [DB-1:0] d, input logic pbit, input logic stopb);
    logic perr;
    perr = (PAR_EN != 0) ? (pbit ^ (^d)) : 1'b0;
    exp_q.push_back({perr, ~stopb, d});
    n_sent++;
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (PAR_EN != 0) send_bit(pbit);
    send_bit(stopb);
  endtask

  initial begin
    int n0;
    logic [DB-1:0] d;
    logic pbit;
    logic stopb;

    reset   = 1'b1;
    rx_line = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(rx_busy), 32'd0);

    // Good parity, then a corrupted parity bit.
    tdiv = 4;
    idle_bits(2);
    send_frame(8'hA5, 1'b0, 1'b1);
    idle_bits(1);
    send_frame(8'h01, 1'b1, 1'b1);
    idle_bits(1);
    send_frame(8'hA5, 1'b1, 1'b1);
    idle_bits(2);
    chk("hold_data", 32'(rx_data), 32'hA5);
    chk("hold_perr", 32'(parity_err), (PAR_EN != 0) ? 32'd1 : 32'd0);

    // Stop bit low with the line held low: one frame, then break.
    n0 = n_valid;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (19 * OS * tdiv) @(negedge clk);
    chk("break_busy", 32'(rx_busy), 32'd1);
    chk("break_count", 32'(n_valid), 32'(n0 + 1));
    chk("break_ferr_hold", 32'(frame_err), 32'd1);
    idle_bits(1);
    chk("break_release", 32'(rx_busy), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle_bits(1);

    // Short low pulse: glitch rejected at mid-start-bit.
    n0 = n_valid;
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch_busy_hi", 32'(rx_busy), 32'd1);
    repeat (4 * tdiv - 3) @(negedge clk);
    rx_line = 1'b1;
    repeat (6 * tdiv + 6) @(negedge clk);
    chk("glitch_busy_lo", 32'(rx_busy), 32'd0);
    idle_bits(2);
    chk("glitch_count", 32'(n_valid), 32'(n0));

    // Zero idle time between frames.
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    idle_bits(1);
    chk("b2b_spacing", 32'(t_last - t_prev), 32'(NBITS * OS * tdiv));

    // os_tick held high permanently.
    tdiv = 1;
    idle_bits(2);
    send_frame(8'h0F, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    idle_bits(1);
    chk("b2b_spacing_fast", 32'(t_last - t_prev), 32'(NBITS * OS));

    // Reset in the middle of data bit 3 of 0xFF.
    tdiv = 4;
    idle_bits(2);
    n0 = n_valid;
    rx_line = 1'b0;
    repeat (OS * tdiv) @(negedge clk);
    rx_line = 1'b1;
    repeat (3 * OS * tdiv + OS * tdiv / 2) @(negedge clk);
    chk("pre_reset_busy", 32'(rx_busy), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_busy", 32'(rx_busy), 32'd0);
    reset = 1'b0;
    idle_bits(3);
    chk("abort_count", 32'(n_valid), 32'(n0));
    chk("abort_data", 32'(rx_data), 32'd0);
    send_frame(8'h12, 1'b0, 1'b1);
    idle_bits(2);

    // Random frames: random data, occasional bad parity or bad stop bit,
    // random gaps including none.
    tdiv = 2;
    idle_bits(1);
    for (int k = 0; k < 16; k++) begin
      d     = DB'($urandom);
      pbit  = (^d) ^ ($urandom_range(0, 3) == 0);
      stopb = ($urandom_range(0, 7) != 0);
      send_frame(d, pbit, stopb);
      if (!stopb) idle_bits(1 + $urandom_range(0, 1));
      else idle_bits($urandom_range(0, 2));
    end
    idle_bits(2);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("frame_count", 32'(n_valid), 32'(n_sent));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
